vector_seq_alu: RTL and testbench

//  Multi-beat vector execute unit; successor to the fixed 6-element single-cycle vector ALU.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/vector_lane_alu.sv | 68 ++++++
 rtl/vector_seq_alu.sv | 144 ++++++++++++++
 tb/tb_vector_seq_alu.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and helpers for the vector execute unit.
package cpu_pkg;

    localparam int unsigned ALU_CTRL_WIDTH = 3;

    typedef enum logic [ALU_CTRL_WIDTH-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6,
        ALU_MUL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } vec_alu_state_e;

    // Number of beats needed to cover a vector with the given lane count
    function automatic int unsigned vecBeats(input int unsigned vectorSize,
                                             input int unsigned numLanes);
        return (vectorSize + numLanes - 1) / numLanes;
    endfunction

endpackage

// File: rtl/vector_lane_alu.sv
// Combinational single-element ALU used by each physical lane.
// Optional build macro: VEC_ALU_SATURATE_EN clamps add/sub results to the signed range.
module vector_lane_alu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  alu_op_e               op,
    output logic [DATA_WIDTH-1:0] res,
    output logic                  n,
    output logic                  z,
    output logic                  v,
    output logic                  c
);

    localparam int unsigned MSB  = DATA_WIDTH - 1;
    localparam int unsigned SH_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH:0]   wide;
    logic [DATA_WIDTH-1:0] raw;
    logic                  ovf;
    logic [SH_W-1:0]       shAmt;

    assign shAmt = b[SH_W-1:0];

    // Operation select, carry/overflow generation and optional clamp
    always_comb begin
        res  = '0;
        wide = '0;
        raw  = '0;
        ovf  = 1'b0;
        c    = 1'b0;
        case (op)
            ALU_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                raw  = wide[DATA_WIDTH-1:0];
                c    = wide[DATA_WIDTH];
                ovf  = (a[MSB] == b[MSB]) && (raw[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                raw  = wide[DATA_WIDTH-1:0];
                c    = ~wide[DATA_WIDTH];
                ovf  = (a[MSB] != b[MSB]) && (raw[MSB] != a[MSB]);
            end
            ALU_AND: raw = a & b;
            ALU_OR:  raw = a | b;
            ALU_XOR: raw = a ^ b;
            ALU_SHL: raw = a << shAmt;
            ALU_SHR: raw = a >> shAmt;
            ALU_MUL: raw = a * b;
            default: raw = '0;
        endcase
        res = raw;
`ifdef VEC_ALU_SATURATE_EN
        // Overflow direction follows the sign of operand a for both add and sub
        if (ovf) begin
            res = a[MSB] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
`endif
        v = ovf;
        n = res[MSB];
        z = (res == '0);
    end

endmodule

// File: rtl/vector_seq_alu.sv
// Multi-beat vector execute unit: VECTOR_SIZE elements over NUM_LANES lane ALUs.
// Optional build macro: VEC_ALU_SATURATE_EN (saturating add/sub inside the lanes).
module vector_seq_alu #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned VECTOR_SIZE    = 6,
    parameter int unsigned NUM_LANES      = 2,
    parameter int unsigned ALU_CTRL_WIDTH = 3
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              inValid,
    output logic                              inReady,
    input  logic [ALU_CTRL_WIDTH-1:0]         aluControl,
    input  logic                              isScalarInstruction,
    input  logic                              isVectorScalarOperation,
    input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] vectorOperand1,
    input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] vectorOperand2,
    input  logic [DATA_WIDTH-1:0]             scalarOperand,
    output logic                              outValid,
    input  logic                              outReady,
    output logic [VECTOR_SIZE*DATA_WIDTH-1:0] result,
    output logic                              N,
    output logic                              Z,
    output logic                              V,
    output logic                              C
);

    import cpu_pkg::*;

    localparam int unsigned VEC_W  = VECTOR_SIZE * DATA_WIDTH;
    localparam int unsigned BEATS  = vecBeats(VECTOR_SIZE, NUM_LANES);
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned IDX_W  = $clog2(BEATS * NUM_LANES + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    vec_alu_state_e        state;
    logic [BEAT_W-1:0]     beat;
    logic [VEC_W-1:0]      opA;
    logic [VEC_W-1:0]      opB;
    alu_op_e               opSel;
    logic                  scalarOp;
    logic                  accept;

    logic [DATA_WIDTH-1:0] laneA   [NUM_LANES];
    logic [DATA_WIDTH-1:0] laneB   [NUM_LANES];
    logic [DATA_WIDTH-1:0] laneRes [NUM_LANES];
    logic [IDX_W-1:0]      laneIdx [NUM_LANES];
    logic [NUM_LANES-1:0]  laneActive;
    logic [NUM_LANES-1:0]  laneElem0;
    logic [NUM_LANES-1:0]  laneN, laneZ, laneV, laneC;

    assign inReady = (state == IDLE) || ((state == DONE) && outReady);
    assign accept  = inValid && inReady;

    // Per-lane element selection for the current beat and the lane ALUs
    for (genvar l = 0; l < NUM_LANES; l++) begin : gLane
        logic [IDX_W-1:0] elemIdx;
        assign elemIdx = IDX_W'(beat) * IDX_W'(NUM_LANES) + IDX_W'(l);
        assign laneActive[l] = (state == RUN) && (elemIdx < IDX_W'(VECTOR_SIZE))
                               && (!scalarOp || (elemIdx == '0));
        assign laneElem0[l]  = laneActive[l] && (elemIdx == '0);
        assign laneIdx[l]    = laneActive[l] ? elemIdx : '0;
        assign laneA[l]      = opA[laneIdx[l]*DATA_WIDTH +: DATA_WIDTH];
        assign laneB[l]      = opB[laneIdx[l]*DATA_WIDTH +: DATA_WIDTH];

        vector_lane_alu #(.DATA_WIDTH(DATA_WIDTH)) uLaneAlu (
            .a   (laneA[l]),
            .b   (laneB[l]),
            .op  (opSel),
            .res (laneRes[l]),
            .n   (laneN[l]),
            .z   (laneZ[l]),
            .v   (laneV[l]),
            .c   (laneC[l])
        );
    end

    // Control FSM, operand latches, beat counter and result/flag registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            beat     <= '0;
            opA      <= '0;
            opB      <= '0;
            opSel    <= ALU_ADD;
            scalarOp <= 1'b0;
            result   <= '0;
            outValid <= 1'b0;
            N        <= 1'b0;
            Z        <= 1'b0;
            V        <= 1'b0;
            C        <= 1'b0;
        end else begin
            case (state)
                IDLE: ;
                RUN: begin
                    for (int l = 0; l < NUM_LANES; l++) begin
                        if (laneActive[l]) begin
                            result[laneIdx[l]*DATA_WIDTH +: DATA_WIDTH] <= laneRes[l];
                        end
                    end
                    if (|laneElem0) begin
                        N <= |(laneN & laneElem0);
                        Z <= |(laneZ & laneElem0);
                        V <= |(laneV & laneElem0);
                        C <= |(laneC & laneElem0);
                    end
                    if (scalarOp || (beat == LAST_BEAT)) begin
                        state    <= DONE;
                        outValid <= 1'b1;
                        beat     <= '0;
                    end else begin
                        beat <= beat + BEAT_W'(1);
                    end
                end
                DONE: begin
                    if (outReady) begin
                        outValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // New operation: latch operands (broadcast folded in) and clear the result
            if (accept) begin
                state    <= RUN;
                beat     <= '0;
                opA      <= vectorOperand1;
                opB      <= (isVectorScalarOperation && !isScalarInstruction)
                            ? {VECTOR_SIZE{scalarOperand}} : vectorOperand2;
                opSel    <= alu_op_e'(aluControl);
                scalarOp <= isScalarInstruction;
                result   <= '0;
                outValid <= 1'b0;
                N        <= 1'b0;
                Z        <= 1'b0;
                V        <= 1'b0;
                C        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vector_seq_alu.sv
// Scoreboard bench for vector_seq_alu: a 6-element/2-lane instance and a 5-element/2-lane instance.
module tb_vector_seq_alu;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;
    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Instance 0: VECTOR_SIZE=6, NUM_LANES=2
    logic        iv0, ir0, sc0, vs0, ov0, or0, n0, z0, v0, c0;
    logic [2:0]  ctl0;
    logic [95:0] a0, b0, res0;
    logic [15:0] s0;
    // Instance 1: VECTOR_SIZE=5, NUM_LANES=2
    logic        iv1, ir1, sc1, vs1, ov1, or1, n1, z1, v1, c1;
    logic [2:0]  ctl1;
    logic [79:0] a1, b1, res1;
    logic [15:0] s1;

    vector_seq_alu #(.DATA_WIDTH(16), .VECTOR_SIZE(6), .NUM_LANES(2), .ALU_CTRL_WIDTH(3)) dut0 (
        .clock(clock), .reset(reset), .inValid(iv0), .inReady(ir0), .aluControl(ctl0),
        .isScalarInstruction(sc0), .isVectorScalarOperation(vs0), .vectorOperand1(a0),
        .vectorOperand2(b0), .scalarOperand(s0), .outValid(ov0), .outReady(or0),
        .result(res0), .N(n0), .Z(z0), .V(v0), .C(c0));

    vector_seq_alu #(.DATA_WIDTH(16), .VECTOR_SIZE(5), .NUM_LANES(2), .ALU_CTRL_WIDTH(3)) dut1 (
        .clock(clock), .reset(reset), .inValid(iv1), .inReady(ir1), .aluControl(ctl1),
        .isScalarInstruction(sc1), .isVectorScalarOperation(vs1), .vectorOperand1(a1),
        .vectorOperand2(b1), .scalarOperand(s1), .outValid(ov1), .outReady(or1),
        .result(res1), .N(n1), .Z(z1), .V(v1), .C(c1));

    typedef struct {
        logic [95:0] res;
        logic [3:0]  nzvc;
        int unsigned cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                           OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_MUL = 3'd7;

    function automatic logic [95:0] pk(input logic [15:0] e0, e1, e2, e3, e4, e5);
        return {e5, e4, e3, e2, e1, e0};
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor for instance 0: compare each new result against the scoreboard head
    initial begin : mon0
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clock);
            if (reset && ov0 && !prev) begin
                if (q0.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL dut0 unexpected output: got %h, expected none", res0);
                end else begin
                    e = q0.pop_front();
                    check("dut0 result", res0, e.res);
                    check("dut0 flags NZVC", 96'({n0, z0, v0, c0}), 96'(e.nzvc));
                    check("dut0 latency cycle", 96'(cyc), 96'(e.cyc));
                end
            end
            prev = ov0;
        end
    end

    // Monitor for instance 1
    initial begin : mon1
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clock);
            if (reset && ov1 && !prev) begin
                if (q1.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL dut1 unexpected output: got %h, expected none", res1);
                end else begin
                    e = q1.pop_front();
                    check("dut1 result", {16'h0, res1}, e.res);
                    check("dut1 flags NZVC", 96'({n1, z1, v1, c1}), 96'(e.nzvc));
                    check("dut1 latency cycle", 96'(cyc), 96'(e.cyc));
                end
            end
            prev = ov1;
        end
    end

    // Issue one operation, wait (bounded) for inReady, push the expected response
    task automatic send(input int d, input logic [2:0] op, input logic sc, input logic vsc,
                        input logic [95:0] a, input logic [95:0] b, input logic [15:0] s,
                        input logic [95:0] er, input logic [3:0] ef, input int unsigned lat);
        exp_t e;
        int k;
        @(negedge clock);
        if (d == 0) begin
            ctl0 = op; sc0 = sc; vs0 = vsc; a0 = a; b0 = b; s0 = s; iv0 = 1'b1;
        end else begin
            ctl1 = op; sc1 = sc; vs1 = vsc; a1 = a[79:0]; b1 = b[79:0]; s1 = s; iv1 = 1'b1;
        end
        #1;
        k = 0;
        while ((((d == 0) ? ir0 : ir1) !== 1'b1) && (k < 50)) begin
            @(negedge clock); #1;
            k++;
        end
        if (k == 50) begin
            tests++; fails++;
            $display("FAIL inReady timeout dut%0d: got 0, expected 1", d);
        end
        e.res = er; e.nzvc = ef; e.cyc = cyc + 1 + lat;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge clock); #1;
        if (d == 0) iv0 = 1'b0; else iv1 = 1'b0;
    endtask

    initial begin : stim
        exp_t e;
        int k;
        reset = 1'b0;
        iv0 = 0; sc0 = 0; vs0 = 0; ctl0 = '0; a0 = '0; b0 = '0; s0 = '0; or0 = 1'b1;
        iv1 = 0; sc1 = 0; vs1 = 0; ctl1 = '0; a1 = '0; b1 = '0; s1 = '0; or1 = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("reset outValid", 96'(ov0), 96'(0));
        check("reset inReady", 96'(ir0), 96'(1));
        check("reset result", res0, 96'(0));
        check("reset flags", 96'({n0, z0, v0, c0}), 96'(0));
        @(negedge clock);
        reset = 1'b1;

        // T1: reset asserted while an operation is in RUN
        @(negedge clock);
        ctl0 = OP_ADD; a0 = pk(1, 2, 3, 4, 5, 6); b0 = pk(1, 1, 1, 1, 1, 1); iv0 = 1'b1;
        @(posedge clock); #1; iv0 = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrun reset outValid", 96'(ov0), 96'(0));
        check("midrun reset result", res0, 96'(0));
        check("midrun reset inReady", 96'(ir0), 96'(1));
        check("midrun reset flags", 96'({n0, z0, v0, c0}), 96'(0));
        @(negedge clock);
        reset = 1'b1;

        // T2: vector add, 3 beats
        send(0, OP_ADD, 0, 0, pk(1, 2, 3, 4, 5, 6), pk(10, 20, 30, 40, 50, 60), 16'h0,
             pk(11, 22, 33, 44, 55, 66), 4'b0000, 3);

        // Vector add with carry from element 0 and signed overflow in element 1
`ifdef VEC_ALU_SATURATE_EN
        send(0, OP_ADD, 0, 0, pk(16'hFFFF, 16'h7FFF, 1, 2, 3, 4), pk(1, 1, 1, 1, 1, 1), 16'h0,
             pk(0, 16'h7FFF, 2, 3, 4, 5), 4'b0101, 3);
`else
        send(0, OP_ADD, 0, 0, pk(16'hFFFF, 16'h7FFF, 1, 2, 3, 4), pk(1, 1, 1, 1, 1, 1), 16'h0,
             pk(0, 16'h8000, 2, 3, 4, 5), 4'b0101, 3);
`endif

        // T4: scalar sub 0x8000-1, other elements forced to 0
`ifdef VEC_ALU_SATURATE_EN
        send(0, OP_SUB, 1, 0, pk(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000),
             pk(1, 1, 1, 1, 1, 1), 16'h0, pk(16'h8000, 0, 0, 0, 0, 0), 4'b1011, 1);
`else
        send(0, OP_SUB, 1, 0, pk(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000),
             pk(1, 1, 1, 1, 1, 1), 16'h0, pk(16'h7FFF, 0, 0, 0, 0, 0), 4'b0011, 1);
`endif

        // Vector sub with borrow in element 0 and overflow in element 3
`ifdef VEC_ALU_SATURATE_EN
        send(0, OP_SUB, 0, 0, pk(5, 100, 0, 16'h8000, 7, 1), pk(7, 1, 1, 1, 7, 1), 16'h0,
             pk(16'hFFFE, 16'h0063, 16'hFFFF, 16'h8000, 0, 0), 4'b1000, 3);
`else
        send(0, OP_SUB, 0, 0, pk(5, 100, 0, 16'h8000, 7, 1), pk(7, 1, 1, 1, 7, 1), 16'h0,
             pk(16'hFFFE, 16'h0063, 16'hFFFF, 16'h7FFF, 0, 0), 4'b1000, 3);
`endif

        // T6: shl by broadcast 17 (masked to 1), then scalar mul wrapping to zero
        send(0, OP_SHL, 0, 1, pk(3, 1, 2, 4, 16'h8000, 5), pk(16'hFFFF, 16'hFFFF, 16'hFFFF,
             16'hFFFF, 16'hFFFF, 16'hFFFF), 16'h0011, pk(6, 2, 4, 8, 0, 10), 4'b0000, 3);
        send(0, OP_MUL, 1, 1, pk(16'h0100, 2, 2, 2, 2, 2), pk(16'h0100, 3, 3, 3, 3, 3), 16'h5555,
             pk(0, 0, 0, 0, 0, 0), 4'b0100, 1);

        // Logical shift right with masked amounts
        send(0, OP_SHR, 0, 0, pk(16'h8000, 16'hF0F0, 16'h1234, 1, 16'hFFFF, 16'h0010),
             pk(4, 20, 0, 1, 15, 3), 16'h0, pk(16'h0800, 16'h0F0F, 16'h1234, 0, 1, 2), 4'b0000, 3);

        // T3: 5-element instance, vector-scalar xor
        send(1, OP_XOR, 0, 1, pk(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F, 0),
             pk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0), 16'h00FF,
             pk(16'h12CB, 16'h5687, 16'h9A43, 16'hDE0F, 16'h0FF0, 0), 4'b0000, 3);
`ifdef VEC_ALU_SATURATE_EN
        send(1, OP_ADD, 0, 0, pk(1, 2, 3, 4, 5, 0), pk(16'h7FFF, 1, 1, 1, 1, 0), 16'h0,
             pk(16'h7FFF, 3, 4, 5, 6, 0), 4'b0010, 3);
`else
        send(1, OP_ADD, 0, 0, pk(1, 2, 3, 4, 5, 0), pk(16'h7FFF, 1, 1, 1, 1, 0), 16'h0,
             pk(16'h8000, 3, 4, 5, 6, 0), 4'b1010, 3);
`endif

        // T5: backpressure, held result, ignored request, then back-to-back accept
        or0 = 1'b0;
        send(0, OP_AND, 0, 0, pk(16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0),
             pk(16'hFF00, 16'h0FF0, 16'h00FF, 16'hF00F, 16'hFFFF, 0), 16'h0,
             pk(16'hF000, 16'h00F0, 16'h00F0, 16'hF000, 16'hF0F0, 0), 4'b1000, 3);
        k = 0;
        while (ov0 !== 1'b1 && k < 10) begin
            @(negedge clock);
            k++;
        end
        if (k == 10) begin
            tests++; fails++;
            $display("FAIL outValid timeout: got 0, expected 1");
        end
        for (int i = 0; i < 5; i++) begin
            ctl0 = OP_ADD; sc0 = 0; vs0 = 0; a0 = '1; b0 = '1; iv0 = 1'b1;
            #1;
            check("hold outValid", 96'(ov0), 96'(1));
            check("hold inReady", 96'(ir0), 96'(0));
            check("hold result", res0, pk(16'hF000, 16'h00F0, 16'h00F0, 16'hF000, 16'hF0F0, 0));
            @(negedge clock);
        end
        ctl0 = OP_OR; a0 = pk(1, 16'h10, 16'h100, 16'h1000, 0, 16'h8000);
        b0 = pk(2, 16'h20, 16'h200, 16'h2000, 0, 0); or0 = 1'b1; iv0 = 1'b1;
        #1;
        check("back-to-back inReady", 96'(ir0), 96'(1));
        e.res = pk(3, 16'h30, 16'h300, 16'h3000, 0, 16'h8000); e.nzvc = 4'b0000; e.cyc = cyc + 1 + 3;
        q0.push_back(e);
        @(posedge clock); #1;
        iv0 = 1'b0;

        // Drain the scoreboards with a bounded wait
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 100) begin
            @(negedge clock);
            k++;
        end
        @(negedge clock);
        if (q0.size() != 0 || q1.size() != 0) begin
            tests++; fails++;
            $display("FAIL scoreboard drain: got %0d pending, expected 0", q0.size() + q1.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "time limit");
    end

endmodule
